// File: rtl/ll_fifo_pkg.sv
// Shared types and defaults for linked_list_fifo and its drain arbiter.
package ll_fifo_pkg;

   localparam int unsigned WIDTH_DEF     = 4;
   localparam int unsigned NUM_FIFOS_DEF = 2;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n < 2) ? 32'd1 : 32'($clog2(n));
   endfunction

   localparam int unsigned SEL_WIDTH_DEF = sel_width(NUM_FIFOS_DEF);

   typedef logic [SEL_WIDTH_DEF-1:0] qid_t;

   typedef struct packed {
      logic [WIDTH_DEF-1:0] data;
      qid_t                 qid;
   } out_entry_t;

endpackage

// File: rtl/ll_fifo_drain_arbiter_if.sv
// FIFO-side and consumer-side signals of the drain arbiter; master is the arbiter.
interface ll_fifo_drain_arbiter_if
   import ll_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter int unsigned NUM_FIFOS = NUM_FIFOS_DEF,
   parameter int unsigned SEL_WIDTH = sel_width(NUM_FIFOS)
);
   logic [NUM_FIFOS-1:0] empty;
   logic [WIDTH-1:0]     fifo_data;
   logic [NUM_FIFOS-1:0] pause;
   logic                 pop;
   logic [SEL_WIDTH-1:0] pop_sel;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_data;
   logic [SEL_WIDTH-1:0] out_qid;

   modport master (
      input  empty, fifo_data, pause, out_ready,
      output pop, pop_sel, out_valid, out_data, out_qid
   );

   modport slave (
      output empty, fifo_data, pause, out_ready,
      input  pop, pop_sel, out_valid, out_data, out_qid
   );

endinterface

// File: rtl/ll_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or after start_i, wrapping mod N.
module ll_rr_pick #(
   parameter int unsigned N  = 2,
   parameter int unsigned SW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [SW-1:0] start_i,
   output logic [SW-1:0] grant_o,
   output logic          any_o
);
   localparam int unsigned SW1 = SW + 1;

   logic [N-1:0] rot;
   logic [SW:0]  sum;
   logic         found;

   always_comb begin
      // rot[i] == req_i[(start_i + i) mod N] for any N, power of two or not
      rot     = N'({req_i, req_i} >> start_i);
      found   = 1'b0;
      sum     = '0;
      grant_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            sum   = {1'b0, start_i} + SW1'(i);
            if (sum >= SW1'(N)) sum = sum - SW1'(N);
            grant_o = sum[SW-1:0];
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/ll_fifo_drain_arbiter.sv
// Round-robin drain of linked_list_fifo queues into a 2-entry tagged output buffer.
// Optional DRAIN_BURST_EN keeps the grant on one queue for up to BURST_LEN pops.
module ll_fifo_drain_arbiter
   import ll_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter int unsigned NUM_FIFOS = NUM_FIFOS_DEF,
   parameter int unsigned SEL_WIDTH = sel_width(NUM_FIFOS),
   parameter int unsigned BURST_LEN = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ll_fifo_drain_arbiter_if.master bus
);
   typedef struct packed {
      logic [WIDTH-1:0]     data;
      logic [SEL_WIDTH-1:0] qid;
   } entry_t;

   if (NUM_FIFOS < 2) begin : g_bad_num_fifos
      $error("ll_fifo_drain_arbiter: NUM_FIFOS must be >= 2");
   end
   if (BURST_LEN < 1) begin : g_bad_burst_len
      $error("ll_fifo_drain_arbiter: BURST_LEN must be >= 1");
   end

   localparam logic [SEL_WIDTH-1:0] LAST_Q = SEL_WIDTH'(NUM_FIFOS - 1);

   logic [NUM_FIFOS-1:0] elig;
   logic [SEL_WIDTH-1:0] grant;
   logic                 any_elig;
   logic                 pop;
   logic                 deq;
   logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [1:0]           occ_q, occ_d;
   entry_t               ent0_q, ent0_d, ent1_q, ent1_d;
   entry_t               cap;

   function automatic logic [SEL_WIDTH-1:0] next_q(input logic [SEL_WIDTH-1:0] q);
      return (q == LAST_Q) ? '0 : q + 1'b1;
   endfunction

   assign elig = ~bus.empty & ~bus.pause;

   ll_rr_pick #(.N(NUM_FIFOS), .SW(SEL_WIDTH)) u_pick (
      .req_i   (elig),
      .start_i (rr_ptr_q),
      .grant_o (grant),
      .any_o   (any_elig)
   );

   // occ_q is registered, so out_ready never reaches pop combinationally
   assign pop = rst_n & any_elig & (occ_q != 2'd2);
   assign deq = (occ_q != 2'd0) & bus.out_ready;
   assign cap = '{data: bus.fifo_data, qid: grant};

   assign bus.pop       = pop;
   assign bus.pop_sel   = grant;
   assign bus.out_valid = (occ_q != 2'd0);
   assign bus.out_data  = ent0_q.data;
   assign bus.out_qid   = ent0_q.qid;

   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q;
      if (deq) begin
         ent0_d = ent1_q;
         occ_d  = occ_q - 1'b1;
      end
      if (pop) begin
         if (occ_d == 2'd0) ent0_d = cap;
         else               ent1_d = cap;
         occ_d = occ_d + 1'b1;
      end
   end

`ifdef DRAIN_BURST_EN
   localparam int unsigned CW = sel_width(BURST_LEN + 1);

   logic [CW-1:0] burst_cnt_q, burst_cnt_d, cnt_next;

   // While a burst is open rr_ptr_q stays on the bursting queue so the picker re-grants it.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      cnt_next    = (grant == rr_ptr_q) ? burst_cnt_q + 1'b1 : CW'(1);
      if (pop) begin
         if (32'(cnt_next) >= BURST_LEN) begin
            rr_ptr_d    = next_q(grant);
            burst_cnt_d = '0;
         end else begin
            rr_ptr_d    = grant;
            burst_cnt_d = cnt_next;
         end
      end else if ((burst_cnt_q != '0) && !elig[rr_ptr_q]) begin
         rr_ptr_d    = next_q(rr_ptr_q);
         burst_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) burst_cnt_q <= '0;
      else        burst_cnt_q <= burst_cnt_d;
   end
`else
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (pop) rr_ptr_d = next_q(grant);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         occ_q    <= '0;
         ent0_q   <= '0;
         ent1_q   <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         occ_q    <= occ_d;
         ent0_q   <= ent0_d;
         ent1_q   <= ent1_d;
      end
   end

endmodule

// File: tb/tb_ll_fifo_drain_arbiter.sv
// Directed bench for ll_fifo_drain_arbiter with a 2-queue linked_list_fifo stand-in.
// Build with +define+DRAIN_BURST_EN to exercise the burst variant (BURST_LEN=3).
module tb_ll_fifo_drain_arbiter;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   ll_fifo_drain_arbiter_if #(.WIDTH(4), .NUM_FIFOS(2)) bus ();

`ifdef DRAIN_BURST_EN
   localparam int unsigned BL = 3;
`else
   localparam int unsigned BL = 4;
`endif

   ll_fifo_drain_arbiter #(.WIDTH(4), .NUM_FIFOS(2), .BURST_LEN(BL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   logic [3:0] qmem  [2][8];
   logic [2:0] qhead [2] = '{default: '0};
   logic [3:0] qcnt  [2] = '{default: '0};
   logic       load_en;
   logic       load_q;
   logic [3:0] load_val;
   logic       bad_pop = 1'b0;

   assign bus.empty     = {qcnt[1] == 4'd0, qcnt[0] == 4'd0};
   assign bus.fifo_data = qmem[bus.pop_sel][qhead[bus.pop_sel]];

   always @(posedge clk) begin
      logic [3:0] nc;
      for (int i = 0; i < 2; i++) begin
         nc = qcnt[i];
         if (bus.pop && bus.pop_sel == 1'(i)) begin
            if (qcnt[i] == 4'd0) bad_pop <= 1'b1;
            qhead[i] <= qhead[i] + 3'd1;
            nc = nc - 4'd1;
         end
         if (load_en && load_q == 1'(i)) begin
            qmem[i][qhead[i] + qcnt[i][2:0]] <= load_val;
            nc = nc + 4'd1;
         end
         qcnt[i] <= nc;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load(input logic q, input logic [3:0] v);
      @(negedge clk);
      load_en  = 1'b1;
      load_q   = q;
      load_val = v;
      @(posedge clk);
      #1 load_en = 1'b0;
   endtask

   task automatic exp_cyc(input string tag, input logic p, input logic sel,
                          input logic v, input logic [3:0] d, input logic q);
      #1;
      check({tag, ".pop"}, 32'(bus.pop), 32'(p));
      if (p) check({tag, ".sel"}, 32'(bus.pop_sel), 32'(sel));
      check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
      if (v) begin
         check({tag, ".data"}, 32'(bus.out_data), 32'(d));
         check({tag, ".qid"}, 32'(bus.out_qid), 32'(q));
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      load_en       = 1'b0;
      load_q        = 1'b0;
      load_val      = '0;
      bus.pause     = '1;
      bus.out_ready = 1'b0;

      repeat (3) tick();
      exp_cyc("reset", 0, 0, 0, 0, 0);
      check("reset.data", 32'(bus.out_data), 0);
      check("reset.qid", 32'(bus.out_qid), 0);
      tick(); rst_n = 1'b1;

      // fill buffer from q0 only, then reset mid-stream with q1 eligible
      load(0, 4'h5); load(0, 4'h6); load(1, 4'h8);
      tick(); bus.pause = 2'b10; exp_cyc("rst_a0", 1, 0, 0, 0, 0);
      tick(); exp_cyc("rst_a1", 1, 0, 1, 4'h5, 0);
      tick(); exp_cyc("rst_a2", 0, 0, 1, 4'h5, 0);
      tick(); rst_n = 1'b0; bus.pause = 2'b00;
      exp_cyc("rst_mid", 0, 0, 0, 0, 0);
      check("rst_mid.data", 32'(bus.out_data), 0);
      check("rst_mid.qid", 32'(bus.out_qid), 0);
      load(0, 4'h7);
      tick(); rst_n = 1'b1; bus.out_ready = 1'b1;
      exp_cyc("rst_b0", 1, 0, 0, 0, 0);
      tick(); exp_cyc("rst_b1", 1, 1, 1, 4'h7, 0);
      tick(); exp_cyc("rst_b2", 0, 0, 1, 4'h8, 1);
      tick(); exp_cyc("rst_b3", 0, 0, 0, 0, 0);

`ifdef DRAIN_BURST_EN
      begin
         logic [11:0] bseq;
         logic        pv, pq;
         logic [3:0]  pd;
         logic [3:0]  n0, n1;
         bseq = 12'b000111000111;
         bus.pause = '1;
         for (int i = 0; i < 6; i++) load(0, 4'(i));
         for (int i = 0; i < 6; i++) load(1, 4'(8 + i));
         tick(); bus.pause = 2'b00;
         pv = 1'b0; pd = '0; pq = 1'b0; n0 = '0; n1 = '0;
         for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            exp_cyc($sformatf("burst%0d", i), 1, bseq[11-i], pv, pd, pq);
            pv = 1'b1;
            pq = bseq[11-i];
            if (pq) begin pd = 4'h8 + n1; n1++; end
            else    begin pd = n0;        n0++; end
         end
         tick(); exp_cyc("burst_end0", 0, 0, 1, 4'hD, 1);
         tick(); exp_cyc("burst_end1", 0, 0, 0, 0, 0);
      end
`else
      // strict alternation with back-to-back drain
      bus.pause = '1;
      load(0, 4'h1); load(0, 4'h2); load(0, 4'h3);
      load(1, 4'h9); load(1, 4'hA); load(1, 4'hB);
      tick(); bus.pause = 2'b00; exp_cyc("alt0", 1, 0, 0, 0, 0);
      tick(); exp_cyc("alt1", 1, 1, 1, 4'h1, 0);
      tick(); exp_cyc("alt2", 1, 0, 1, 4'h9, 1);
      tick(); exp_cyc("alt3", 1, 1, 1, 4'h2, 0);
      tick(); exp_cyc("alt4", 1, 0, 1, 4'hA, 1);
      tick(); exp_cyc("alt5", 1, 1, 1, 4'h3, 0);
      tick(); exp_cyc("alt6", 0, 0, 1, 4'hB, 1);
      tick(); exp_cyc("alt7", 0, 0, 0, 0, 0);

      // backpressure: two pops fill the buffer, head held until ready
      bus.pause = '1; bus.out_ready = 1'b0;
      load(0, 4'h4); load(0, 4'h5); load(1, 4'h6); load(1, 4'h7);
      tick(); bus.pause = 2'b00; exp_cyc("bp0", 1, 0, 0, 0, 0);
      tick(); exp_cyc("bp1", 1, 1, 1, 4'h4, 0);
      tick(); exp_cyc("bp2", 0, 0, 1, 4'h4, 0);
      tick(); bus.out_ready = 1'b1; exp_cyc("bp3", 0, 0, 1, 4'h4, 0);
      tick(); exp_cyc("bp4", 1, 0, 1, 4'h6, 1);
      tick(); exp_cyc("bp5", 1, 1, 1, 4'h5, 0);
      tick(); exp_cyc("bp6", 0, 0, 1, 4'h7, 1);
      tick(); exp_cyc("bp7", 0, 0, 0, 0, 0);

      // q0 paused: only q1 served, then alternation resumes from rr_ptr
      bus.pause = '1;
      load(0, 4'hC); load(0, 4'hD); load(1, 4'hE); load(1, 4'hF);
      tick(); bus.pause = 2'b01; exp_cyc("pz0", 1, 1, 0, 0, 0);
      tick(); exp_cyc("pz1", 1, 1, 1, 4'hE, 1);
      tick(); exp_cyc("pz2", 0, 0, 1, 4'hF, 1);
      tick(); bus.pause = 2'b00; exp_cyc("pz3", 1, 0, 0, 0, 0);
      tick(); exp_cyc("pz4", 1, 0, 1, 4'hC, 0);
      tick(); exp_cyc("pz5", 0, 0, 1, 4'hD, 0);
      tick(); exp_cyc("pz6", 0, 0, 0, 0, 0);

      // single last element: exactly one pop
      bus.pause = '1;
      load(0, 4'hA);
      tick(); bus.pause = 2'b00; exp_cyc("one0", 1, 0, 0, 0, 0);
      tick(); exp_cyc("one1", 0, 0, 1, 4'hA, 0);
      tick(); exp_cyc("one2", 0, 0, 0, 0, 0);
`endif

      check("no_empty_pop", 32'(bad_pop), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ll_fifo_drain_arbiter.md
Name: ll_fifo_drain_arbiter

Overview:
Egress stage directly downstream of linked_list_fifo.
- Watches the per-queue empty vector and picks a non-empty, unpaused queue round-robin.
- Issues pop/pop_sel to the shared FIFO and captures its data_out into a 2-entry output buffer.
- Presents the captured data with a valid/ready handshake, tagged with the source queue id.

Parameters:
WIDTH, 4, data width; must match linked_list_fifo WIDTH
NUM_FIFOS, 2, number of logical queues; must be >= 2 (elaboration error otherwise)
SEL_WIDTH, $clog2(NUM_FIFOS), width of pop_sel and out_qid
BURST_LEN, 4, maximum consecutive pops from one queue; used only with DRAIN_BURST_EN; must be >= 1

Ports:
clk  input  1  clock; all state on posedge
rst_n  input  1  reset, asynchronous, active-low
empty  input  NUM_FIFOS  per-queue empty from linked_list_fifo; bit i reflects the state after the most recent clock edge
fifo_data  input  WIDTH  linked_list_fifo data_out; combinational head of the queue selected by pop_sel
pause  input  NUM_FIFOS  queue i is ineligible while pause[i]=1
pop  output  1  pop strobe to linked_list_fifo
pop_sel  output  SEL_WIDTH  queue being popped; meaningful only when pop=1
out_valid  output  1  output buffer head valid
out_ready  input  1  consumer accepts the head when out_valid & out_ready
out_data  output  WIDTH  head data
out_qid  output  SEL_WIDTH  source queue of the head

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - buffer emptied, out_valid=0, rr_ptr=0, burst_cnt=0.
  - pop forced to 0 while rst_n=0.
  - out_data and out_qid read 0.
- Eligibility: elig[i] = ~empty[i] & ~pause[i].
- Pick: rotating priority starting at rr_ptr; grant the first eligible index in rr_ptr, rr_ptr+1, ... with wrap modulo NUM_FIFOS (correct for non-power-of-2 NUM_FIFOS).
- Pop rule: pop = rst_n & any(elig) & (occ < 2), where occ is the buffer occupancy (0..2).
  - occ is registered, so there is no combinational path from out_ready to pop.
  - pop_sel = grant.
- Capture: on a clock edge with pop=1, {fifo_data, pop_sel} is written to the buffer tail.
  - Latency: pop in cycle t, out_valid=1 in cycle t+1 when the buffer was empty.
- Buffer: 2-entry in-order FIFO.
  - occ_next = occ + pop - (out_valid & out_ready).
  - Simultaneous capture and dequeue at occ=1 keeps occ at 1, which gives 1 beat/cycle sustained.
  - Entries are never reordered or dropped.
- rr_ptr update (no burst): after a pop, rr_ptr <= (grant+1) mod NUM_FIFOS. It is unchanged in cycles without a pop.
- Last element of a queue: a pop at cycle t drains it; empty[q]=1 is seen from t+1, so q is not popped again. The block never pops a queue whose empty bit is 1.
- pause asserted in the same cycle as a would-be grant: that queue is skipped that cycle.
- All queues ineligible, or occ=2: pop=0 and rr_ptr holds.
- out_data and out_qid stay stable while out_valid=1 and out_ready=0.

Optional Feature:
Macro DRAIN_BURST_EN.
- Defined:
  - After a pop from q, the grant sticks to q while elig[q] holds and burst_cnt < BURST_LEN-1; burst_cnt increments per pop.
  - When the burst ends (limit reached or q ineligible): rr_ptr <= (q+1) mod NUM_FIFOS and burst_cnt <= 0.
  - A cycle with no pop (for example occ=2) preserves burst_cnt and the sticky grant.
- Not defined: burst_cnt does not exist; behaviour is identical to BURST_LEN=1.

Decomposition:
- Package ll_fifo_pkg holds:
  - default WIDTH and NUM_FIFOS localparams;
  - the SEL_WIDTH computation;
  - a queue-id typedef;
  - a packed out-entry struct {data, qid}.
  linked_list_fifo shares this package.
- One sub-module, ll_rr_pick: purely combinational rotating-priority picker (req vector, start pointer -> grant index, any_grant).
- The buffer, rr_ptr and burst logic stay in ll_fifo_drain_arbiter.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0 and pop=0 in the same cycle, without waiting for a clock edge. After release, the first grant goes to queue 0.
- NUM_FIFOS=2, both queues hold 3 entries (q0: 1,2,3; q1: 9,A,B), out_ready=1 -> pop_sel 0,1,0,1,0,1 on consecutive cycles; out_data 1,9,2,A,3,B with out_qid 0,1,0,1,0,1, first valid one cycle after the first pop.
- out_ready=0, both queues non-empty -> exactly 2 pops, then pop=0 and out_data held at the first entry. Raising out_ready drains in order and pops resume the cycle after occ drops below 2.
- pause=2'b01, both queues non-empty -> only pop_sel=1 issued. Clearing pause then resumes alternation starting from the rr_ptr value.
- q0 holds single entry 0xA, q1 empty -> one pop at t, pop=0 at t+1 (empty[0]=1), out_data=0xA, out_qid=0.
- DRAIN_BURST_EN, BURST_LEN=3, both queues hold 6 entries, out_ready=1 -> pop_sel sequence 0,0,0,1,1,1,0,0,0.
